instr_loader: RTL and testbench



---
 rtl/instr_loader_pkg.sv | 18 +
 rtl/instr_loader_if.sv | 30 +++
 rtl/instr_loader_byte_assembler.sv | 68 ++++++
 rtl/instr_loader.sv | 113 +++++++++++
 tb/tb_instr_loader.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/instr_loader_pkg.sv
// Shared definitions for the instruction loader: FSM state encoding and the
// default end-of-program marker (also used by the debug unit).
package instr_loader_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [31:0] DEFAULT_END_WORD = 32'hFFFF_FFFF;

  function automatic logic [31:0] word_addr(input logic [31:0] idx,
                                            input int unsigned step);
    return idx * 32'(step);
  endfunction

endpackage

// File: rtl/instr_loader_if.sv
// Byte-stream input and instruction-memory write bus of the loader.
// The slave modport is the loader; the master modport is its environment.
interface instr_loader_if #(
  parameter int unsigned MAX_WORDS = 64
);
  localparam int unsigned CW = $clog2(MAX_WORDS) + 1;

  logic          i_start;
  logic [7:0]    i_rx_data;
  logic          i_rx_valid;
  logic          o_we;
  logic [31:0]   o_inst_addr;
  logic [31:0]   o_instr_data;
  logic          o_cpu_hold;
  logic          o_done;
  logic          o_error;
  logic [CW-1:0] o_word_count;

  modport master (
    output i_start, i_rx_data, i_rx_valid,
    input  o_we, o_inst_addr, o_instr_data, o_cpu_hold, o_done, o_error,
           o_word_count
  );

  modport slave (
    input  i_start, i_rx_data, i_rx_valid,
    output o_we, o_inst_addr, o_instr_data, o_cpu_hold, o_done, o_error,
           o_word_count
  );
endinterface

// File: rtl/instr_loader_byte_assembler.sv
// Big-endian byte-to-word assembler with a combinational word_valid pulse on
// the 4th byte. LOADER_TIMEOUT_EN adds an idle timeout that drops partial words.
module instr_loader_byte_assembler
`ifdef LOADER_TIMEOUT_EN
#(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
)
`endif
(
  input  logic        clk,
  input  logic        i_rst,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_valid,
  output logic        timeout
);

  logic [23:0] shift_q;
  logic [1:0]  cnt_q;

  assign word       = {shift_q, byte_in};
  assign word_valid = byte_valid && (cnt_q == 2'd3);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (clear || timeout) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (byte_valid) begin
      if (cnt_q == 2'd3) begin
        shift_q <= '0;
        cnt_q   <= '0;
      end else begin
        shift_q <= {shift_q[15:0], byte_in};
        cnt_q   <= cnt_q + 2'd1;
      end
    end
  end

`ifdef LOADER_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] idle_q;

  // A nonzero byte count only exists in LOAD, so it doubles as the arm condition.
  assign timeout = (cnt_q != 2'd0) && !byte_valid &&
                   (idle_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      idle_q <= '0;
    end else if (clear || byte_valid || timeout || (cnt_q == 2'd0)) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_q + TW'(1);
    end
  end
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: rtl/instr_loader.sv
// Instruction loader: assembles a UART byte stream into words, writes them to
// instruction memory and holds the CPU until done. Optional: LOADER_TIMEOUT_EN.
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter logic [31:0] END_WORD  = DEFAULT_END_WORD,
  parameter int unsigned MAX_WORDS = 64,
  parameter int unsigned ADDR_STEP = 4
`ifdef LOADER_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 1_000_000
`endif
) (
  input  logic           clk,
  input  logic           i_rst,
  instr_loader_if.slave  bus
);

  localparam int unsigned CW = $clog2(MAX_WORDS) + 1;

  state_e        state_q, state_d;
  logic          accept;
  logic [31:0]   word;
  logic          word_valid;
  logic          timeout;
  logic          write_fire;
  logic          overflow;
  logic          we_q;
  logic          error_q;
  logic [31:0]   addr_q;
  logic [31:0]   data_q;
  logic [CW-1:0] count_q;

  // A byte coinciding with i_start belongs to no load and is dropped.
  assign accept = bus.i_rx_valid && !bus.i_start && (state_q == LOAD);

  instr_loader_byte_assembler
`ifdef LOADER_TIMEOUT_EN
    #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES))
`endif
  u_asm (
    .clk       (clk),
    .i_rst     (i_rst),
    .clear     (bus.i_start),
    .byte_valid(accept),
    .byte_in   (bus.i_rx_data),
    .word      (word),
    .word_valid(word_valid),
    .timeout   (timeout)
  );

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    write_fire = 1'b0;
    overflow   = 1'b0;
    case (state_q)
      IDLE: if (bus.i_start) state_d = LOAD;
      LOAD: begin
        if (bus.i_start) begin
          state_d = LOAD;
        end else if (word_valid) begin
          if (word == END_WORD) begin
            state_d = DONE;
          end else if (count_q == CW'(MAX_WORDS)) begin
            overflow = 1'b1;
            state_d  = DONE;
          end else begin
            write_fire = 1'b1;
          end
        end
      end
      DONE:    if (bus.i_start) state_d = LOAD;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      count_q <= '0;
      error_q <= 1'b0;
    end else begin
      we_q <= write_fire;
      if (bus.i_start) begin
        addr_q  <= '0;
        count_q <= '0;
      end else if (write_fire) begin
        addr_q  <= word_addr(32'(count_q), ADDR_STEP);
        data_q  <= word;
        count_q <= count_q + CW'(1);
      end
      if (bus.i_start)              error_q <= 1'b0;
      else if (overflow || timeout) error_q <= 1'b1;
    end
  end

  assign bus.o_we         = we_q;
  assign bus.o_inst_addr  = addr_q;
  assign bus.o_instr_data = data_q;
  assign bus.o_word_count = count_q;
  assign bus.o_error      = error_q;
  assign bus.o_done       = (state_q == DONE);
  assign bus.o_cpu_hold   = (state_q != DONE);

endmodule

// File: tb/tb_instr_loader.sv
// Directed self-checking bench for instr_loader: expected writes are queued
// when the 4th byte is driven and compared when o_we is seen.
module tb_instr_loader;
  import instr_loader_pkg::*;

  localparam int unsigned MAXW = 2;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instr_loader_if #(.MAX_WORDS(MAXW)) bus ();

  instr_loader #(
    .MAX_WORDS(MAXW)
`ifdef LOADER_TIMEOUT_EN
    , .TIMEOUT_CYCLES(16)
`endif
  ) dut (
    .clk  (clk),
    .i_rst(rst),
    .bus  (bus)
  );

  wr_t exp_q[$];
  int  checks  = 0;
  int  errors  = 0;
  int  nedge   = 0;
  int  m_count = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
    end
  endtask

  // Write monitor: pops the scoreboard on every sampled o_we cycle.
  always @(negedge clk) begin
    wr_t e;
    nedge = nedge + 1;
    if (bus.o_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("write_pending", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", bus.o_inst_addr, e.addr);
        check("wr_data", bus.o_instr_data, e.data);
        check("wr_cycle", 32'(nedge), 32'(e.cyc));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      bus.i_rx_valid = 1'b0;
      bus.i_start    = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    bus.i_start    = 1'b0;
    bus.i_rx_valid = 1'b1;
    bus.i_rx_data  = b;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap, input bit exp_wr);
    for (int i = 0; i < 4; i++) begin
      send_byte(w[31-8*i -: 8]);
      if (i == 3 && exp_wr) begin
        exp_q.push_back('{addr: 32'(m_count) * 32'd4, data: w, cyc: nedge + 2});
        m_count++;
      end
      if (gap > 0 && i < 3) tick(gap);
    end
  endtask

  task automatic pulse_start(input bit with_byte);
    @(posedge clk); #1;
    bus.i_start    = 1'b1;
    bus.i_rx_valid = with_byte;
    bus.i_rx_data  = 8'hEE;
    @(posedge clk); #1;
    bus.i_start    = 1'b0;
    bus.i_rx_valid = 1'b0;
    m_count        = 0;
  endtask

  task automatic check_status(input string tag, input logic hold, input logic done,
                              input logic err, input logic [31:0] cnt);
    check({tag, "_hold"},  bus.o_cpu_hold, hold);
    check({tag, "_done"},  bus.o_done, done);
    check({tag, "_error"}, bus.o_error, err);
    check({tag, "_count"}, 32'(bus.o_word_count), cnt);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  initial begin
    bus.i_start    = 1'b0;
    bus.i_rx_valid = 1'b0;
    bus.i_rx_data  = 8'h00;
    rst            = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_status("reset", 1'b1, 1'b0, 1'b0, 32'd0);
    check("reset_we", bus.o_we, 32'd0);
    check("reset_addr", bus.o_inst_addr, 32'd0);
    check("reset_data", bus.o_instr_data, 32'd0);
    rst = 1'b0;
    tick(2);

    send_word(32'h0102_0304, 0, 1'b0);
    tick(3);
    check_status("idle_bytes", 1'b1, 1'b0, 1'b0, 32'd0);

    pulse_start(1'b0);
    check_status("armed", 1'b1, 1'b0, 1'b0, 32'd0);
    send_word(32'h2008_0005, 1, 1'b1);
    send_word(32'h2009_0007, 2, 1'b1);
    send_word(DEFAULT_END_WORD, 0, 1'b0);
    tick(3);
    check_status("nominal", 1'b0, 1'b1, 1'b0, 32'd2);
    check("nominal_drained", 32'(exp_q.size()), 32'd0);

    send_word(32'h0BAD_BEEF, 0, 1'b0);
    tick(3);
    check_status("done_bytes", 1'b0, 1'b1, 1'b0, 32'd2);

    pulse_start(1'b0);
    check_status("rearm", 1'b1, 1'b0, 1'b0, 32'd0);
    send_word(32'hA1A2_A3A4, 0, 1'b1);
    send_word(32'hB1B2_B3B4, 0, 1'b1);
    tick(3);
    check_status("b2b", 1'b1, 1'b0, 1'b0, 32'd2);
    check("b2b_drained", 32'(exp_q.size()), 32'd0);

    send_word(32'h5566_7788, 0, 1'b0);
    tick(3);
    check_status("overflow", 1'b0, 1'b1, 1'b1, 32'd2);

    pulse_start(1'b0);
    check_status("restart_clear", 1'b1, 1'b0, 1'b0, 32'd0);
    send_word(32'hCAFE_F00D, 0, 1'b1);
    pulse_start(1'b0);
    tick(2);
    check_status("sched_write", 1'b1, 1'b0, 1'b0, 32'd0);
    check("sched_drained", 32'(exp_q.size()), 32'd0);

    send_byte(8'h5A);
    send_byte(8'hA5);
    pulse_start(1'b1);
    send_word(32'h1122_3344, 0, 1'b1);
    tick(3);
    check_status("restart", 1'b1, 1'b0, 1'b0, 32'd1);
    check("restart_drained", 32'(exp_q.size()), 32'd0);

`ifdef LOADER_TIMEOUT_EN
    pulse_start(1'b0);
    send_byte(8'h77);
    tick(16);
    check("timeout_pre_error", bus.o_error, 32'd0);
    tick(1);
    check_status("timeout", 1'b1, 1'b0, 1'b1, 32'd0);
    send_word(32'hAABB_CCDD, 0, 1'b1);
    tick(3);
    check_status("timeout_after", 1'b1, 1'b0, 1'b1, 32'd1);
    check("timeout_drained", 32'(exp_q.size()), 32'd0);
`endif

    pulse_start(1'b0);
    send_byte(8'h12);
    send_byte(8'h34);
    tick(1);
    rst = 1'b1;
    #3;
    check_status("reset_midload", 1'b1, 1'b0, 1'b0, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    pulse_start(1'b0);
    send_word(32'h0F1E_2D3C, 0, 1'b1);
    tick(3);
    check_status("after_reset", 1'b1, 1'b0, 1'b0, 32'd1);
    check("final_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
